// File: rtl/execute_stage_if.sv
// Decode-side and writeback-side handshake bundle of the execute stage.
// The stage uses the slave view; the producer/consumer pair uses the master view.
interface execute_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [6:0]      op_class;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      rd_index;
    logic [XLEN-1:0] rd_value;
    logic            rd_write_enable;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            illegal;

    modport master (
        output in_valid, instruction, op_class, pc, rs1_value, rs2_value, out_ready,
        input  in_ready, out_valid, rd_index, rd_value, rd_write_enable,
               redirect_valid, redirect_pc, illegal
    );

    modport slave (
        input  in_valid, instruction, op_class, pc, rs1_value, rs2_value, out_ready,
        output in_ready, out_valid, rd_index, rd_value, rd_write_enable,
               redirect_valid, redirect_pc, illegal
    );
endinterface

// File: rtl/execute_stage.sv
// Registered RV32I/RV64I execute stage: ALU, branch/jump redirect, illegal-op
// detection, and an optional bit-serial shifter that stalls intake while busy.
module execute_stage #(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 1,
    parameter int SHW          = $clog2(XLEN)
) (
    input logic            clock,
    input logic            reset,
    execute_stage_if.slave io
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
    typedef enum logic [1:0] {SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2} shift_e;

    localparam logic [6:0] OC_RR    = 7'b1000000;
    localparam logic [6:0] OC_RI    = 7'b0100000;
    localparam logic [6:0] OC_AUIPC = 7'b0010000;
    localparam logic [6:0] OC_LUI   = 7'b0001000;
    localparam logic [6:0] OC_JAL   = 7'b0000100;
    localparam logic [6:0] OC_JALR  = 7'b0000010;
    localparam logic [6:0] OC_BR    = 7'b0000001;
    // Immediate-shift upper bits that must be zero; bit 30 selects arithmetic.
    localparam logic [31:0] HI_MASK = ~((32'd1 << (20 + SHW)) - 32'd1) & ~32'h4000_0000;

    state_e          state_q;
    shift_e          shift_kind_q;
    logic [XLEN-1:0] shift_val_q;
    logic [SHW-1:0]  shift_cnt_q;
    logic            out_valid_q;
    logic [4:0]      rd_index_q;
    logic [XLEN-1:0] rd_value_q;
    logic            rd_we_q;
    logic            redir_valid_q;
    logic [XLEN-1:0] redir_pc_q;
    logic            illegal_q;

    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s, imm_b_s, imm_j_s, imm_u_s;
    logic [XLEN-1:0] op_b_s, jalr_sum_s;
    logic            is_rr_s;
    logic [SHW-1:0]  shamt_s;
    logic            unused_opcode_s;

    assign funct3_s   = io.instruction[14:12];
    assign funct7_s   = io.instruction[31:25];
    assign imm_i_s    = XLEN'($signed(io.instruction[31:20]));
    assign imm_b_s    = XLEN'($signed({io.instruction[31], io.instruction[7],
                                       io.instruction[30:25], io.instruction[11:8], 1'b0}));
    assign imm_j_s    = XLEN'($signed({io.instruction[31], io.instruction[19:12],
                                       io.instruction[20], io.instruction[30:21], 1'b0}));
    assign imm_u_s    = XLEN'($signed({io.instruction[31:12], 12'h000}));
    assign is_rr_s    = (io.op_class == OC_RR);
    assign op_b_s     = is_rr_s ? io.rs2_value : imm_i_s;
    assign jalr_sum_s = io.rs1_value + imm_i_s;
    assign shamt_s    = is_rr_s ? io.rs2_value[SHW-1:0] : io.instruction[20 +: SHW];
    assign unused_opcode_s = ^io.instruction[6:0];

    logic [XLEN-1:0] alu_res_s;
    logic            alu_legal_s;
    logic            alu_shift_s;
    shift_e          alu_kind_s;

    // Integer ALU for reg-reg and reg-imm forms, with funct3/funct7 legality.
    always_comb begin
        alu_res_s   = {XLEN{1'b0}};
        alu_legal_s = 1'b1;
        alu_shift_s = 1'b0;
        alu_kind_s  = SH_SLL;
        case (funct3_s)
            3'b000: begin
                if (is_rr_s && (funct7_s == 7'h20)) begin
                    alu_res_s = io.rs1_value - op_b_s;
                end else begin
                    alu_res_s = io.rs1_value + op_b_s;
                end
                alu_legal_s = !is_rr_s || (funct7_s == 7'h00) || (funct7_s == 7'h20);
            end
            3'b001: begin
                alu_shift_s = 1'b1;
                alu_kind_s  = SH_SLL;
                alu_legal_s = is_rr_s ? (funct7_s == 7'h00)
                                      : (((io.instruction & HI_MASK) == 32'd0) && !io.instruction[30]);
            end
            3'b010: begin
                alu_res_s   = XLEN'($signed(io.rs1_value) < $signed(op_b_s));
                alu_legal_s = !is_rr_s || (funct7_s == 7'h00);
            end
            3'b011: begin
                alu_res_s   = XLEN'(io.rs1_value < op_b_s);
                alu_legal_s = !is_rr_s || (funct7_s == 7'h00);
            end
            3'b100: begin
                alu_res_s   = io.rs1_value ^ op_b_s;
                alu_legal_s = !is_rr_s || (funct7_s == 7'h00);
            end
            3'b101: begin
                alu_shift_s = 1'b1;
                alu_kind_s  = io.instruction[30] ? SH_SRA : SH_SRL;
                alu_legal_s = is_rr_s ? ((funct7_s == 7'h00) || (funct7_s == 7'h20))
                                      : ((io.instruction & HI_MASK) == 32'd0);
            end
            3'b110: begin
                alu_res_s   = io.rs1_value | op_b_s;
                alu_legal_s = !is_rr_s || (funct7_s == 7'h00);
            end
            3'b111: begin
                alu_res_s   = io.rs1_value & op_b_s;
                alu_legal_s = !is_rr_s || (funct7_s == 7'h00);
            end
            default: alu_legal_s = 1'b0;
        endcase
        // Serial mode only reaches here with shamt==0, where the result is the operand.
        if (alu_shift_s) begin
            if (SERIAL_SHIFT != 0) begin
                alu_res_s = io.rs1_value;
            end else begin
                case (alu_kind_s)
                    SH_SLL:  alu_res_s = io.rs1_value << shamt_s;
                    SH_SRL:  alu_res_s = io.rs1_value >> shamt_s;
                    SH_SRA:  alu_res_s = $signed(io.rs1_value) >>> shamt_s;
                    default: alu_res_s = io.rs1_value;
                endcase
            end
        end else begin
            alu_res_s = alu_res_s;
        end
    end

    logic            br_taken_s;
    logic            br_legal_s;

    // Branch condition evaluation.
    always_comb begin
        br_taken_s = 1'b0;
        br_legal_s = 1'b1;
        case (funct3_s)
            3'b000:  br_taken_s = (io.rs1_value == io.rs2_value);
            3'b001:  br_taken_s = (io.rs1_value != io.rs2_value);
            3'b100:  br_taken_s = ($signed(io.rs1_value) <  $signed(io.rs2_value));
            3'b101:  br_taken_s = ($signed(io.rs1_value) >= $signed(io.rs2_value));
            3'b110:  br_taken_s = (io.rs1_value <  io.rs2_value);
            3'b111:  br_taken_s = (io.rs1_value >= io.rs2_value);
            default: br_legal_s = 1'b0;
        endcase
    end

    logic [XLEN-1:0] res_s;
    logic [XLEN-1:0] target_s;
    logic            we_s;
    logic            take_s;
    logic            illegal_s;
    logic            is_shift_s;

    // Per-class result, write enable, redirect and legality.
    always_comb begin
        res_s      = {XLEN{1'b0}};
        target_s   = {XLEN{1'b0}};
        we_s       = 1'b0;
        take_s     = 1'b0;
        illegal_s  = 1'b0;
        is_shift_s = 1'b0;
        case (io.op_class)
            OC_RR, OC_RI: begin
                res_s      = alu_res_s;
                we_s       = 1'b1;
                illegal_s  = !alu_legal_s;
                is_shift_s = alu_shift_s;
            end
            OC_AUIPC: begin
                res_s = io.pc + imm_u_s;
                we_s  = 1'b1;
            end
            OC_LUI: begin
                res_s = imm_u_s;
                we_s  = 1'b1;
            end
            OC_JAL: begin
                res_s    = io.pc + XLEN'(4);
                we_s     = 1'b1;
                take_s   = 1'b1;
                target_s = io.pc + imm_j_s;
            end
            OC_JALR: begin
                res_s     = io.pc + XLEN'(4);
                we_s      = 1'b1;
                take_s    = 1'b1;
                target_s  = {jalr_sum_s[XLEN-1:1], 1'b0};
                illegal_s = (funct3_s != 3'b000);
            end
            OC_BR: begin
                take_s    = br_taken_s;
                target_s  = io.pc + imm_b_s;
                illegal_s = !br_legal_s;
            end
            default: illegal_s = 1'b1;
        endcase
        if (take_s && target_s[1]) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = illegal_s;
        end
        if (illegal_s || (io.instruction[11:7] == 5'd0)) begin
            we_s = 1'b0;
        end else begin
            we_s = we_s;
        end
        if (illegal_s) begin
            take_s = 1'b0;
        end else begin
            take_s = take_s;
        end
    end

    logic            in_ready_s;
    logic            accept_s;
    logic            go_serial_s;
    logic [XLEN-1:0] shift_step_s;

    assign in_ready_s  = !reset && (state_q == ST_IDLE) && (!out_valid_q || io.out_ready);
    assign accept_s    = io.in_valid && in_ready_s;
    assign go_serial_s = (SERIAL_SHIFT != 0) && is_shift_s && !illegal_s && (shamt_s != {SHW{1'b0}});

    // One-bit shift step of the serial shifter.
    always_comb begin
        case (shift_kind_q)
            SH_SLL:  shift_step_s = {shift_val_q[XLEN-2:0], 1'b0};
            SH_SRL:  shift_step_s = {1'b0, shift_val_q[XLEN-1:1]};
            SH_SRA:  shift_step_s = {shift_val_q[XLEN-1], shift_val_q[XLEN-1:1]};
            default: shift_step_s = shift_val_q;
        endcase
    end

    // Control FSM and output payload registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_kind_q  <= SH_SLL;
            shift_val_q   <= {XLEN{1'b0}};
            shift_cnt_q   <= {SHW{1'b0}};
            out_valid_q   <= 1'b0;
            rd_index_q    <= 5'd0;
            rd_value_q    <= {XLEN{1'b0}};
            rd_we_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= {XLEN{1'b0}};
            illegal_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        rd_index_q    <= io.instruction[11:7];
                        rd_we_q       <= we_s;
                        redir_valid_q <= take_s;
                        redir_pc_q    <= target_s;
                        illegal_q     <= illegal_s;
                        if (go_serial_s) begin
                            shift_val_q  <= io.rs1_value;
                            shift_cnt_q  <= shamt_s;
                            shift_kind_q <= alu_kind_s;
                            out_valid_q  <= 1'b0;
                            state_q      <= ST_SHIFT;
                        end else begin
                            rd_value_q  <= res_s;
                            out_valid_q <= 1'b1;
                        end
                    end else if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (shift_cnt_q == SHW'(1)) begin
                        rd_value_q  <= shift_step_s;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        shift_val_q <= shift_step_s;
                        shift_cnt_q <= shift_cnt_q - SHW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign io.in_ready        = in_ready_s;
    assign io.out_valid       = out_valid_q;
    assign io.rd_index        = rd_index_q;
    assign io.rd_value        = rd_value_q;
    assign io.rd_write_enable = rd_we_q;
    assign io.redirect_valid  = redir_valid_q;
    assign io.redirect_pc     = redir_pc_q;
    assign io.illegal         = illegal_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage: a serial-shift instance carries
// the vector table and corner sequences, a barrel-shift instance checks latency 1.
module tb_execute_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    execute_stage_if #(.XLEN(32)) ifa ();
    execute_stage_if #(.XLEN(32)) ifb ();

    execute_stage #(.XLEN(32), .SERIAL_SHIFT(1)) dut   (.clock(clock), .reset(reset), .io(ifa));
    execute_stage #(.XLEN(32), .SERIAL_SHIFT(0)) dut_b (.clock(clock), .reset(reset), .io(ifb));

    localparam logic [6:0] RR = 7'b1000000, RI = 7'b0100000, AU = 7'b0010000, LU = 7'b0001000;
    localparam logic [6:0] JA = 7'b0000100, JR = 7'b0000010, BR = 7'b0000001;
    localparam logic [6:0] OP_I = 7'b0010011, OP_JALR = 7'b1100111;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  oc;
        logic [31:0] pc, rs1, rs2;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        chk_val, we, rv;
        logic [31:0] rpc;
        logic        ill;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [0:NV-1];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, 5'd1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic vec_t mk(input logic [31:0] instr, input logic [6:0] oc, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd,
                                input logic [31:0] val, input logic chk_val, input logic we,
                                input logic rv, input logic [31:0] rpc, input logic ill);
        vec_t v;
        v.instr = instr; v.oc = oc; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.val = val; v.chk_val = chk_val; v.we = we; v.rv = rv; v.rpc = rpc; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        ifa.instruction = v.instr; ifa.op_class = v.oc; ifa.pc = v.pc;
        ifa.rs1_value = v.rs1; ifa.rs2_value = v.rs2; ifa.in_valid = 1'b1;
    endtask

    // Waits (bounded) for in_ready, takes the accept edge, then drops in_valid.
    task automatic accept_a(input string name);
        int n = 0;
        while (!ifa.in_ready && n < 60) begin @(posedge clock); #1; n++; end
        chk({name, "_accept"}, 64'(ifa.in_ready), 64'd1);
        @(posedge clock); #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic wait_out_a(input string name);
        int n = 0;
        while (!ifa.out_valid && n < 60) begin @(posedge clock); #1; n++; end
        chk({name, "_valid"}, 64'(ifa.out_valid), 64'd1);
    endtask

    initial begin
        vec_t v;
        int   low, seen;
        vt[0]  = mk(enc_i(12'hFFF, 3'b000, 5'd5, OP_I), RI, 32'h0, 32'h10, 32'h0, 5'd5, 32'h0000_000F, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[1]  = mk(enc_r(7'h00, 3'b000, 5'd6), RR, 32'h0, 32'd7, 32'd5, 5'd6, 32'd12, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[2]  = mk(enc_r(7'h20, 3'b000, 5'd7), RR, 32'h0, 32'd5, 32'd7, 5'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[3]  = mk(enc_r(7'h00, 3'b010, 5'd8), RR, 32'h0, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[4]  = mk(enc_r(7'h00, 3'b011, 5'd9), RR, 32'h0, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[5]  = mk(enc_i(12'h0FF, 3'b100, 5'd10, OP_I), RI, 32'h0, 32'hF0F0_F0F0, 32'h0, 5'd10, 32'hF0F0_F00F, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[6]  = mk(enc_i(12'hFF0, 3'b111, 5'd11, OP_I), RI, 32'h0, 32'h1234_5678, 32'h0, 5'd11, 32'h1234_5670, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[7]  = mk(enc_r(7'h20, 3'b101, 5'd12), RR, 32'h0, 32'h8000_0010, 32'h24, 5'd12, 32'hF800_0001, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[8]  = mk(enc_r(7'h00, 3'b001, 5'd13), RR, 32'h0, 32'h1, 32'h23, 5'd13, 32'h8, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[9]  = mk(enc_i(12'h000, 3'b101, 5'd14, OP_I), RI, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd14, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[10] = mk({20'h12345, 5'd15, 7'b0110111}, LU, 32'h0, 32'h0, 32'h0, 5'd15, 32'h1234_5000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[11] = mk({20'h00001, 5'd16, 7'b0010111}, AU, 32'h100, 32'h0, 32'h0, 5'd16, 32'h0000_1100, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[12] = mk({20'hFFFFF, 5'd17, 7'b0010111}, AU, 32'h2000, 32'h0, 32'h0, 5'd17, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vt[13] = mk(enc_j(21'h00100, 5'd1), JA, 32'h40, 32'h0, 32'h0, 5'd1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h140, 1'b0);
        vt[14] = mk(enc_i(12'h004, 3'b000, 5'd1, OP_JALR), JR, 32'h40, 32'h200, 32'h200, 5'd1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h204, 1'b0);
        vt[15] = mk(enc_i(12'h003, 3'b000, 5'd1, OP_JALR), JR, 32'h40, 32'h200, 32'h200, 5'd1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        vt[16] = mk(enc_b(13'h0020, 3'b000), BR, 32'h100, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h120, 1'b0);
        vt[17] = mk(enc_b(13'h0020, 3'b000), BR, 32'h100, 32'd5, 32'd6, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        vt[18] = mk(enc_b(13'h1FF8, 3'b100), BR, 32'h100, 32'hFFFF_FFFF, 32'h0, 5'd25, 32'h0, 1'b0, 1'b0, 1'b1, 32'hF8, 1'b0);
        vt[19] = mk(enc_b(13'h1FF8, 3'b110), BR, 32'h100, 32'h0, 32'hFFFF_FFFF, 5'd25, 32'h0, 1'b0, 1'b0, 1'b1, 32'hF8, 1'b0);
        vt[20] = mk(enc_i(12'h005, 3'b000, 5'd0, OP_I), RI, 32'h0, 32'h0, 32'h0, 5'd0, 32'h5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        vt[21] = mk(enc_i(12'h001, 3'b000, 5'd5, OP_I), 7'b0000011, 32'h0, 32'h1, 32'h0, 5'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        vt[22] = mk(enc_r(7'h01, 3'b000, 5'd6), RR, 32'h0, 32'd1, 32'd1, 5'd6, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        vt[23] = mk(enc_b(13'h0020, 3'b010), BR, 32'h100, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        vt[24] = mk(enc_b(13'h0022, 3'b000), BR, 32'h100, 32'd5, 32'd5, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.instruction = 32'h0; ifa.op_class = 7'h0;
        ifa.pc = 32'h0; ifa.rs1_value = 32'h0; ifa.rs2_value = 32'h0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.instruction = 32'h0; ifb.op_class = 7'h0;
        ifb.pc = 32'h0; ifb.rs1_value = 32'h0; ifb.rs2_value = 32'h0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_in_ready", 64'(ifa.in_ready), 64'd0);
        chk("rst_rd_value", 64'(ifa.rd_value), 64'd0);
        chk("rst_redirect_pc", 64'(ifa.redirect_pc), 64'd0);
        chk("rst_flags", 64'({ifa.rd_write_enable, ifa.redirect_valid, ifa.illegal}), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(ifa.in_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            v = vt[i];
            drive_a(v);
            accept_a(nm);
            wait_out_a(nm);
            chk({nm, "_rd_index"}, 64'(ifa.rd_index), 64'(v.rd));
            chk({nm, "_we"}, 64'(ifa.rd_write_enable), 64'(v.we));
            chk({nm, "_redirect_valid"}, 64'(ifa.redirect_valid), 64'(v.rv));
            chk({nm, "_illegal"}, 64'(ifa.illegal), 64'(v.ill));
            if (v.chk_val) chk({nm, "_rd_value"}, 64'(ifa.rd_value), 64'(v.val));
            if (v.rv) chk({nm, "_redirect_pc"}, 64'(ifa.redirect_pc), 64'(v.rpc));
        end

        // SRAI x3,x2,7 on the serial shifter: in_ready low for exactly 7 cycles.
        v = mk(enc_i(12'h407, 3'b101, 5'd3, OP_I), RI, 32'h0, 32'h8000_0000, 32'h8000_0000,
               5'd3, 32'hFF00_0000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        drive_a(v);
        accept_a("srai_ser");
        low = 0;
        for (int n = 0; n < 40 && !ifa.out_valid; n++) begin
            if (!ifa.in_ready) low++;
            @(posedge clock); #1;
        end
        chk("srai_ser_valid", 64'(ifa.out_valid), 64'd1);
        chk("srai_ser_stall_cycles", 64'(low), 64'd7);
        chk("srai_ser_value", 64'(ifa.rd_value), 64'hFF00_0000);
        chk("srai_ser_in_ready_after", 64'(ifa.in_ready), 64'd1);

        // Same operation on the barrel shifter: result after the accept edge.
        ifb.instruction = v.instr; ifb.op_class = RI; ifb.rs1_value = 32'h8000_0000;
        ifb.rs2_value = 32'h8000_0000; ifb.in_valid = 1'b1;
        #1;
        chk("srai_bar_in_ready", 64'(ifb.in_ready), 64'd1);
        @(posedge clock); #1;
        ifb.in_valid = 1'b0;
        chk("srai_bar_latency1", 64'(ifb.out_valid), 64'd1);
        chk("srai_bar_value", 64'(ifb.rd_value), 64'hFF00_0000);

        // Backpressure: ADD x4 result held for 3 cycles while a new op waits.
        @(posedge clock); #1;
        ifa.out_ready = 1'b0;
        drive_a(mk(enc_r(7'h00, 3'b000, 5'd4), RR, 32'h0, 32'd1, 32'd2, 5'd4, 32'd3, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0));
        @(posedge clock); #1;
        chk("bp_first_valid", 64'(ifa.out_valid), 64'd1);
        drive_a(mk(enc_i(12'h001, 3'b000, 5'd5, OP_I), RI, 32'h0, 32'h100, 32'h0, 5'd5, 32'h101, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            chk($sformatf("bp_hold%0d_valid", k), 64'(ifa.out_valid), 64'd1);
            chk($sformatf("bp_hold%0d_value", k), 64'(ifa.rd_value), 64'd3);
            chk($sformatf("bp_hold%0d_rd", k), 64'(ifa.rd_index), 64'd4);
            chk($sformatf("bp_hold%0d_in_ready", k), 64'(ifa.in_ready), 64'd0);
        end
        ifa.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(ifa.in_ready), 64'd1);
        @(posedge clock); #1;
        ifa.in_valid = 1'b0;
        chk("bp_next_valid", 64'(ifa.out_valid), 64'd1);
        chk("bp_next_value", 64'(ifa.rd_value), 64'h101);
        chk("bp_next_rd", 64'(ifa.rd_index), 64'd5);

        // Reset during cycle 3 of a 10-bit SLLI aborts the operation.
        @(posedge clock); #1;
        drive_a(mk(enc_i(12'h00A, 3'b001, 5'd7, OP_I), RI, 32'h0, 32'h1, 32'h0, 5'd7, 32'h400, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0));
        accept_a("sll_rst");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("sll_rst_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("sll_rst_in_ready_low", 64'(ifa.in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("sll_rst_idle", 64'(ifa.in_ready), 64'd1);
        seen = 0;
        repeat (15) begin
            @(posedge clock); #1;
            if (ifa.out_valid) seen = 1;
        end
        chk("sll_rst_no_result", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
